// File: rtl/ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ptr_ctrl
// Purpose  : Bank of clamped pointer registers with LOAD/INC/DEC/READ/CLEAR
//            and multi-beat BURST emission; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module ptr_ctrl #(
    parameter int PTR_MAX = 4,
    parameter int NREG    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic [2:0] op,
    input  logic [1:0] sel,
    input  logic [7:0] imm,
    output logic [7:0] ptr,
    output logic       ptr_valid,
    output logic       wrap,
    output logic       err
);

    localparam logic [7:0] c_PTR_MAX  = 8'(PTR_MAX);
    localparam logic [2:0] c_OP_LOAD  = 3'b001;
    localparam logic [2:0] c_OP_INC   = 3'b010;
    localparam logic [2:0] c_OP_DEC   = 3'b011;
    localparam logic [2:0] c_OP_READ  = 3'b100;
    localparam logic [2:0] c_OP_CLEAR = 3'b101;
    localparam logic [2:0] c_OP_BURST = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;
    logic [1:0] r_bsel;
    logic [1:0] w_bsel_next;
    logic [7:0] r_regs [NREG];
    logic [7:0] r_ptr;
    logic       r_ptr_valid;
    logic       r_wrap;
    logic       r_err;

    logic       w_sel_ok;
    logic [7:0] w_cur;
    logic [7:0] w_bval;
    logic       w_emit;
    logic [7:0] w_emit_val;
    logic       w_wrap;
    logic       w_wr;
    logic [1:0] w_wr_idx;
    logic [7:0] w_wr_val;
    logic       w_clear;
    logic       w_err_set;

    assign w_sel_ok  = (int'(sel) < NREG);
    assign ready_out = (r_state == ST_IDLE);
    assign ptr       = r_ptr;
    assign ptr_valid = r_ptr_valid;
    assign wrap      = r_wrap;
    assign err       = r_err;

    // Loop-based read keeps the mux safe for NREG smaller than the sel range
    always_comb begin
        w_cur  = '0;
        w_bval = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(sel) == i)    w_cur  = r_regs[i];
            if (int'(r_bsel) == i) w_bval = r_regs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bsel  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bsel  <= w_bsel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bsel_next  = r_bsel;
        w_emit       = 1'b0;
        w_emit_val   = r_ptr;
        w_wrap       = 1'b0;
        w_wr         = 1'b0;
        w_wr_idx     = sel;
        w_wr_val     = '0;
        w_clear      = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_in && w_sel_ok) begin
                    case (op)
                        c_OP_LOAD: begin
                            w_wr      = 1'b1;
                            w_wr_val  = (imm > c_PTR_MAX) ? c_PTR_MAX : imm;
                            w_err_set = (imm > c_PTR_MAX);
                        end
                        c_OP_INC, c_OP_BURST: begin
                            w_emit     = 1'b1;
                            w_emit_val = w_cur;
                            w_wr       = 1'b1;
                            w_wrap     = (w_cur == c_PTR_MAX);
                            w_wr_val   = w_wrap ? 8'd0 : w_cur + 8'd1;
                            // Beat 0 goes out now; remaining beats come from BURST state
                            if (op == c_OP_BURST && imm[2:0] != 3'd0) begin
                                w_state_next = ST_BURST;
                                w_cnt_next   = imm[2:0];
                                w_bsel_next  = sel;
                            end
                        end
                        c_OP_DEC: begin
                            w_emit     = 1'b1;
                            w_emit_val = w_cur;
                            w_wr       = 1'b1;
                            w_wrap     = (w_cur == 8'd0);
                            w_wr_val   = w_wrap ? c_PTR_MAX : w_cur - 8'd1;
                        end
                        c_OP_READ: begin
                            w_emit     = 1'b1;
                            w_emit_val = w_cur;
                        end
                        c_OP_CLEAR: w_clear = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_BURST: begin
                w_emit     = 1'b1;
                w_emit_val = w_bval;
                w_wr       = 1'b1;
                w_wr_idx   = r_bsel;
                w_wrap     = (w_bval == c_PTR_MAX);
                w_wr_val   = w_wrap ? 8'd0 : w_bval + 8'd1;
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst || w_clear) begin
                r_regs[i] <= '0;
            end else if (w_wr && int'(w_wr_idx) == i) begin
                r_regs[i] <= w_wr_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_ptr_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ptr_valid <= w_emit;
            r_wrap      <= w_wrap;
            if (w_emit)    r_ptr <= w_emit_val;
            if (w_clear)   r_err <= 1'b0;
            else if (w_err_set) r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptr_ctrl
// Purpose  : Directed self-checking bench for ptr_ctrl (PTR_MAX=4, NREG=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptr_ctrl;

    localparam logic [2:0] c_NOP   = 3'b000;
    localparam logic [2:0] c_LOAD  = 3'b001;
    localparam logic [2:0] c_INC   = 3'b010;
    localparam logic [2:0] c_DEC   = 3'b011;
    localparam logic [2:0] c_READ  = 3'b100;
    localparam logic [2:0] c_CLEAR = 3'b101;
    localparam logic [2:0] c_BURST = 3'b110;
    localparam logic [2:0] c_RSVD  = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready_out;
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] imm;
    logic [7:0] ptr;
    logic       ptr_valid;
    logic       wrap;
    logic       err;

    int checks   = 0;
    int failures = 0;

    ptr_ctrl #(.PTR_MAX(4), .NREG(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .op        (op),
        .sel       (sel),
        .imm       (imm),
        .ptr       (ptr),
        .ptr_valid (ptr_valid),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single cycle; outputs are sampled afterwards
    task automatic do_cmd(input logic [2:0] o, input logic [1:0] s, input logic [7:0] i);
        valid_in = 1'b1;
        op       = o;
        sel      = s;
        imm      = i;
        step();
        valid_in = 1'b0;
        op       = c_NOP;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] p, input logic v,
                              input logic w, input logic e, input logic r);
        check_eq({tag, ".ptr"},       32'(ptr),       32'(p));
        check_eq({tag, ".ptr_valid"}, 32'(ptr_valid), 32'(v));
        check_eq({tag, ".wrap"},      32'(wrap),      32'(w));
        check_eq({tag, ".err"},       32'(err),       32'(e));
        check_eq({tag, ".ready"},     32'(ready_out), 32'(r));
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; op = c_NOP; sel = '0; imm = '0;
        step(); step();
        expect_out("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        // Basic load/read
        do_cmd(c_LOAD, 2'd1, 8'd3);  expect_out("load1",  8'd0, 0, 0, 0, 1);
        do_cmd(c_READ, 2'd1, 8'd0);  expect_out("read1",  8'd3, 1, 0, 0, 1);
        step();                      expect_out("hold",   8'd3, 0, 0, 0, 1);

        // INC wrap at PTR_MAX; LOAD of exactly PTR_MAX does not set err
        do_cmd(c_LOAD, 2'd0, 8'd4);  expect_out("load4",  8'd3, 0, 0, 0, 1);
        do_cmd(c_INC,  2'd0, 8'd0);  expect_out("incwr",  8'd4, 1, 1, 0, 1);
        do_cmd(c_READ, 2'd0, 8'd0);  expect_out("rdinc",  8'd0, 1, 0, 0, 1);
        do_cmd(c_INC,  2'd0, 8'd0);  expect_out("incnw",  8'd0, 1, 0, 0, 1);

        // DEC wrap at 0
        do_cmd(c_LOAD, 2'd2, 8'd0);  expect_out("load0",  8'd0, 0, 0, 0, 1);
        do_cmd(c_DEC,  2'd2, 8'd0);  expect_out("decwr",  8'd0, 1, 1, 0, 1);
        do_cmd(c_READ, 2'd2, 8'd0);  expect_out("rddec",  8'd4, 1, 0, 0, 1);
        do_cmd(c_DEC,  2'd2, 8'd0);  expect_out("decnw",  8'd4, 1, 0, 0, 1);
        do_cmd(c_READ, 2'd2, 8'd0);  expect_out("rddec2", 8'd3, 1, 0, 0, 1);

        // Clamped load sets sticky err; CLEAR resets registers and err
        do_cmd(c_LOAD, 2'd3, 8'd9);  expect_out("clamp",  8'd3, 0, 0, 1, 1);
        do_cmd(c_NOP,  2'd3, 8'd0);  expect_out("sticky", 8'd3, 0, 0, 1, 1);
        do_cmd(c_READ, 2'd3, 8'd0);  expect_out("rdclmp", 8'd4, 1, 0, 1, 1);
        do_cmd(c_CLEAR, 2'd0, 8'd0); expect_out("clear",  8'd4, 0, 0, 0, 1);
        do_cmd(c_READ, 2'd3, 8'd0);  expect_out("rdclr3", 8'd0, 1, 0, 0, 1);
        do_cmd(c_READ, 2'd1, 8'd0);  expect_out("rdclr1", 8'd0, 1, 0, 0, 1);

        // Reserved op: no emission, no change
        do_cmd(c_LOAD, 2'd1, 8'd2);  expect_out("load2",  8'd0, 0, 0, 0, 1);
        do_cmd(c_RSVD, 2'd1, 8'd0);  expect_out("rsvd",   8'd0, 0, 0, 0, 1);
        do_cmd(c_READ, 2'd1, 8'd0);  expect_out("rdrsvd", 8'd2, 1, 0, 0, 1);

        // Four-beat burst 2,3,4,0 with an ignored command during the busy cycles
        do_cmd(c_LOAD, 2'd0, 8'd2);
        do_cmd(c_BURST, 2'd0, 8'd3); expect_out("beat0",  8'd2, 1, 0, 0, 0);
        valid_in = 1'b1; op = c_LOAD; sel = 2'd0; imm = 8'd3;
        step();                      expect_out("beat1",  8'd3, 1, 0, 0, 0);
        step();                      expect_out("beat2",  8'd4, 1, 1, 0, 0);
        valid_in = 1'b0; op = c_NOP;
        step();                      expect_out("beat3",  8'd0, 1, 0, 0, 1);
        do_cmd(c_READ, 2'd0, 8'd0);  expect_out("rdbrst", 8'd1, 1, 0, 0, 1);

        // Single-beat burst stays idle
        do_cmd(c_BURST, 2'd3, 8'd0); expect_out("bone",   8'd0, 1, 0, 0, 1);
        step();                      expect_out("bonei",  8'd0, 0, 0, 0, 1);
        do_cmd(c_READ, 2'd3, 8'd0);  expect_out("rdbone", 8'd1, 1, 0, 0, 1);

        // Eight-beat burst from 0 aborted by reset on the third beat cycle
        do_cmd(c_LOAD, 2'd2, 8'd0);
        do_cmd(c_BURST, 2'd2, 8'd7); expect_out("ab0",    8'd0, 1, 0, 0, 0);
        step();                      expect_out("ab1",    8'd1, 1, 0, 0, 0);
        step();                      expect_out("ab2",    8'd2, 1, 0, 0, 0);
        rst = 1'b1;
        step();                      expect_out("abrst",  8'd0, 0, 0, 0, 1);
        rst = 1'b0;
        step();                      expect_out("abidle", 8'd0, 0, 0, 0, 1);
        step();                      expect_out("abidl2", 8'd0, 0, 0, 0, 1);
        do_cmd(c_READ, 2'd2, 8'd0);  expect_out("abrd2",  8'd0, 1, 0, 0, 1);
        do_cmd(c_READ, 2'd0, 8'd0);  expect_out("abrd0",  8'd0, 1, 0, 0, 1);

        // Reset wins over a simultaneous command
        rst = 1'b1;
        do_cmd(c_LOAD, 2'd0, 8'd3);  expect_out("rstcmd", 8'd0, 0, 0, 0, 1);
        rst = 1'b0;
        do_cmd(c_READ, 2'd0, 8'd0);  expect_out("rdrst",  8'd0, 1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
